// File: rtl/sobel_line_buffer_controller.sv
// rtl/sobel_line_buffer_controller.sv - two-line RAM sequencer producing 3-row vertical window columns
module sobel_line_buffer_controller #(
  parameter int lineWidth  = 640,
  parameter int maxLines   = 480,
  parameter int pixelWidth = 8,
  localparam int colBits   = $clog2(lineWidth),
  localparam int rowBits   = $clog2(maxLines)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    pixelValid,
  input  logic [pixelWidth-1:0]   pixelIn,
  input  logic                    startOfFrame,
  output logic [colBits-1:0]      ramAddressOut,
  input  logic [2*pixelWidth-1:0] ramDataOut,
  output logic [colBits-1:0]      ramAddressIn,
  output logic                    ramWriteEnable,
  output logic [2*pixelWidth-1:0] ramDataIn,
  output logic                    windowValid,
  output logic [3*pixelWidth-1:0] windowColumn,
  output logic [colBits-1:0]      windowCol,
  output logic [rowBits-1:0]      windowRow,
  output logic                    endOfLine,
  output logic                    endOfFrame,
  output logic                    syncError
);

  localparam logic [colBits-1:0] lastCol  = colBits'(lineWidth - 1);
  localparam logic [rowBits-1:0] lastRow  = rowBits'(maxLines - 1);
  localparam logic [rowBits-1:0] firstOut = rowBits'(2);

  logic [colBits-1:0]      colCount, curCol;
  logic [rowBits-1:0]      rowCount, curRow;
  logic                    sofHit;

  logic                    s1Valid;
  logic [pixelWidth-1:0]   s1Pixel;
  logic [colBits-1:0]      s1Col;
  logic [rowBits-1:0]      s1Row;

  logic                    s2Valid;
  logic [3*pixelWidth-1:0] s2Data;
  logic [colBits-1:0]      s2Col;
  logic [rowBits-1:0]      s2Row;

  // A start-of-frame pixel is always placed at (0,0), whatever the counters say.
  always_comb begin
    sofHit = pixelValid & startOfFrame;
    curCol = sofHit ? '0 : colCount;
    curRow = sofHit ? '0 : rowCount;
  end

  assign ramAddressOut = pixelValid ? curCol : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      colCount  <= '0;
      rowCount  <= '0;
      syncError <= 1'b0;
    end else begin
      syncError <= sofHit && ((colCount != '0) || (rowCount != '0));
      if (pixelValid) begin
        if (curCol == lastCol) begin
          colCount <= '0;
          rowCount <= (curRow == lastRow) ? '0 : curRow + 1'b1;
        end else begin
          colCount <= curCol + 1'b1;
          rowCount <= curRow;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1Valid <= 1'b0;
      s1Pixel <= '0;
      s1Col   <= '0;
      s1Row   <= '0;
    end else begin
      s1Valid <= pixelValid;
      if (pixelValid) begin
        s1Pixel <= pixelIn;
        s1Col   <= curCol;
        s1Row   <= curRow;
      end
    end
  end

  // The RAM word shifts up one row: old mid becomes top, the new pixel becomes mid.
  assign ramWriteEnable = s1Valid;
  assign ramAddressIn   = s1Col;
  assign ramDataIn      = s1Valid ? {ramDataOut[pixelWidth-1:0], s1Pixel} : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s2Valid <= 1'b0;
      s2Data  <= '0;
      s2Col   <= '0;
      s2Row   <= '0;
    end else begin
      s2Valid <= s1Valid;
      if (s1Valid) begin
        s2Data <= {ramDataOut, s1Pixel};
        s2Col  <= s1Col;
        s2Row  <= s1Row;
      end
    end
  end

  // Rows 0 and 1 carry stale RAM contents in the upper slots, so they are never shown.
  always_comb begin
    windowValid  = s2Valid && (s2Row >= firstOut);
    windowColumn = windowValid ? s2Data : '0;
    windowCol    = windowValid ? s2Col : '0;
    windowRow    = windowValid ? s2Row : '0;
    endOfLine    = windowValid && (s2Col == lastCol);
    endOfFrame   = windowValid && (s2Col == lastCol) && (s2Row == lastRow);
  end

endmodule
